// File: rtl/settings.sv
// Settings register bank: a read-only view of 16 constant ROM words merged with
// a writable RAM bank in one flat word address space; every RAM word is exported.
module settings #(
  parameter int unsigned MEMORY_WIDTH      = 32,
  parameter int unsigned ROM_MEMORY_LENGTH = 16,
  parameter int unsigned RAM_MEMORY_LENGTH = 16,
  localparam int unsigned ADDR_WIDTH       = $clog2(ROM_MEMORY_LENGTH + RAM_MEMORY_LENGTH)
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [MEMORY_WIDTH-1:0] data_in,
  output logic [MEMORY_WIDTH-1:0] data_out,
  input  logic [MEMORY_WIDTH-1:0] rom_data_0,
  input  logic [MEMORY_WIDTH-1:0] rom_data_1,
  input  logic [MEMORY_WIDTH-1:0] rom_data_2,
  input  logic [MEMORY_WIDTH-1:0] rom_data_3,
  input  logic [MEMORY_WIDTH-1:0] rom_data_4,
  input  logic [MEMORY_WIDTH-1:0] rom_data_5,
  input  logic [MEMORY_WIDTH-1:0] rom_data_6,
  input  logic [MEMORY_WIDTH-1:0] rom_data_7,
  input  logic [MEMORY_WIDTH-1:0] rom_data_8,
  input  logic [MEMORY_WIDTH-1:0] rom_data_9,
  input  logic [MEMORY_WIDTH-1:0] rom_data_10,
  input  logic [MEMORY_WIDTH-1:0] rom_data_11,
  input  logic [MEMORY_WIDTH-1:0] rom_data_12,
  input  logic [MEMORY_WIDTH-1:0] rom_data_13,
  input  logic [MEMORY_WIDTH-1:0] rom_data_14,
  input  logic [MEMORY_WIDTH-1:0] rom_data_15,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_0,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_1,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_2,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_3,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_4,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_5,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_6,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_7,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_8,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_9,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_10,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_11,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_12,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_13,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_14,
  output logic [MEMORY_WIDTH-1:0] ram_data_out_15
);

  localparam int unsigned EXPORT_PORTS = 16;

  logic [MEMORY_WIDTH-1:0] rom      [EXPORT_PORTS];
  logic [MEMORY_WIDTH-1:0] ram_q    [RAM_MEMORY_LENGTH];
  logic [MEMORY_WIDTH-1:0] ram_d    [RAM_MEMORY_LENGTH];
  logic [MEMORY_WIDTH-1:0] ram_exp  [EXPORT_PORTS];
  logic [MEMORY_WIDTH-1:0] rd_data;

  assign rom[0]  = rom_data_0;
  assign rom[1]  = rom_data_1;
  assign rom[2]  = rom_data_2;
  assign rom[3]  = rom_data_3;
  assign rom[4]  = rom_data_4;
  assign rom[5]  = rom_data_5;
  assign rom[6]  = rom_data_6;
  assign rom[7]  = rom_data_7;
  assign rom[8]  = rom_data_8;
  assign rom[9]  = rom_data_9;
  assign rom[10] = rom_data_10;
  assign rom[11] = rom_data_11;
  assign rom[12] = rom_data_12;
  assign rom[13] = rom_data_13;
  assign rom[14] = rom_data_14;
  assign rom[15] = rom_data_15;

  // Next RAM contents: only an address matching a RAM word is written, so ROM
  // and out-of-range addresses fall through with no state change.
  always_comb begin
    ram_d = ram_q;
    if (wen) begin
      for (int i = 0; i < int'(RAM_MEMORY_LENGTH); i++) begin
        if (addr == ADDR_WIDTH'(int'(ROM_MEMORY_LENGTH) + i)) begin
          ram_d[i] = data_in;
        end
      end
    end
  end

  // Reset wins over a write on the same edge.
  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < int'(RAM_MEMORY_LENGTH); i++) begin
        ram_q[i] <= '0;
      end
    end else begin
      ram_q <= ram_d;
    end
  end

  // Zero-latency read mux over the flat address space; unmapped reads return 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(ROM_MEMORY_LENGTH); i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        rd_data = rom[i];
      end
    end
    for (int i = 0; i < int'(RAM_MEMORY_LENGTH); i++) begin
      if (addr == ADDR_WIDTH'(int'(ROM_MEMORY_LENGTH) + i)) begin
        rd_data = ram_q[i];
      end
    end
  end

  assign data_out = rd_data;

  // Exports beyond the configured RAM size are tied off.
  for (genvar n = 0; n < int'(EXPORT_PORTS); n++) begin : g_export
    if (n < int'(RAM_MEMORY_LENGTH)) begin : g_live
      assign ram_exp[n] = ram_q[n];
    end else begin : g_tie
      assign ram_exp[n] = '0;
    end
  end

  assign ram_data_out_0  = ram_exp[0];
  assign ram_data_out_1  = ram_exp[1];
  assign ram_data_out_2  = ram_exp[2];
  assign ram_data_out_3  = ram_exp[3];
  assign ram_data_out_4  = ram_exp[4];
  assign ram_data_out_5  = ram_exp[5];
  assign ram_data_out_6  = ram_exp[6];
  assign ram_data_out_7  = ram_exp[7];
  assign ram_data_out_8  = ram_exp[8];
  assign ram_data_out_9  = ram_exp[9];
  assign ram_data_out_10 = ram_exp[10];
  assign ram_data_out_11 = ram_exp[11];
  assign ram_data_out_12 = ram_exp[12];
  assign ram_data_out_13 = ram_exp[13];
  assign ram_data_out_14 = ram_exp[14];
  assign ram_data_out_15 = ram_exp[15];

endmodule

// File: tb/tb_settings.sv
// Directed self-checking bench for the settings register bank.
module tb_settings;

  logic        clk = 1'b0;
  logic        rstb;
  logic        wen;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] ro [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  settings dut (
    .clk(clk), .rstb(rstb), .wen(wen), .addr(addr), .data_in(data_in), .data_out(data_out),
    .rom_data_0(32'd0),   .rom_data_1(32'd1),   .rom_data_2(32'd2),   .rom_data_3(32'd3),
    .rom_data_4(32'd4),   .rom_data_5(32'd5),   .rom_data_6(32'd6),   .rom_data_7(32'd7),
    .rom_data_8(32'd8),   .rom_data_9(32'd9),   .rom_data_10(32'd10), .rom_data_11(32'd11),
    .rom_data_12(32'd12), .rom_data_13(32'd13), .rom_data_14(32'd14), .rom_data_15(32'd15),
    .ram_data_out_0(ro[0]),   .ram_data_out_1(ro[1]),   .ram_data_out_2(ro[2]),   .ram_data_out_3(ro[3]),
    .ram_data_out_4(ro[4]),   .ram_data_out_5(ro[5]),   .ram_data_out_6(ro[6]),   .ram_data_out_7(ro[7]),
    .ram_data_out_8(ro[8]),   .ram_data_out_9(ro[9]),   .ram_data_out_10(ro[10]), .ram_data_out_11(ro[11]),
    .ram_data_out_12(ro[12]), .ram_data_out_13(ro[13]), .ram_data_out_14(ro[14]), .ram_data_out_15(ro[15])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every export against an expected image.
  task automatic chk_exports(input string tag, input logic [31:0] exp [16]);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_ram%0d", tag, i), ro[i], exp[i]);
    end
  endtask

  logic [31:0] img [16];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstb = 1'b1; wen = 1'b0; addr = 5'd16; data_in = '0;
    for (int i = 0; i < 16; i++) img[i] = '0;
    for (int i = 0; i < 10; i++) tick();
    addr = 5'd5; #1;
    chk("rom_during_reset", data_out, 32'd5);
    addr = 5'd16;
    rstb = 1'b0;
    tick();
    chk_exports("reset", img);
    chk("reset_rd16", data_out, 32'd0);

    // ROM sweep, no clocking involved
    for (int i = 0; i < 16; i++) begin
      addr = 5'(i); #1;
      chk($sformatf("rom_rd%0d", i), data_out, 32'(i));
    end

    // First RAM word
    addr = 5'd16; data_in = 32'd16; wen = 1'b1;
    tick();
    wen = 1'b0; addr = 5'd0; #1;
    img[0] = 32'd16;
    chk_exports("wr16", img);
    addr = 5'd16; #1;
    chk("rd16_after_wr", data_out, 32'd16);

    // ROM write is ignored
    addr = 5'd3; data_in = 32'h0000_FFFF; wen = 1'b1;
    tick();
    wen = 1'b0; #1;
    chk("rom3_after_wr", data_out, 32'd3);
    chk_exports("romwr", img);

    // Last RAM word
    addr = 5'd31; data_in = 32'h0000_A5A5; wen = 1'b1;
    tick();
    wen = 1'b0; #1;
    chk("ram15_wr", ro[15], 32'h0000_A5A5);
    chk("rd31", data_out, 32'h0000_A5A5);

    // One-cycle reset clears everything
    rstb = 1'b1;
    tick();
    rstb = 1'b0; #1;
    chk("ram15_after_rst", ro[15], 32'd0);
    chk("ram0_after_rst", ro[0], 32'd0);

    // Reset and write on the same edge: reset wins
    rstb = 1'b1; wen = 1'b1; addr = 5'd17; data_in = 32'd7;
    tick();
    rstb = 1'b0; wen = 1'b0; #1;
    chk("rst_vs_wr_ram1", ro[1], 32'd0);
    chk("rst_vs_wr_rd17", data_out, 32'd0);

    // Same write without reset does land
    wen = 1'b1;
    tick();
    wen = 1'b0; #1;
    chk("wr17_ram1", ro[1], 32'd7);
    chk("wr17_rd", data_out, 32'd7);

    // wen held across edges writes each edge's addr/data
    wen = 1'b1; addr = 5'd18; data_in = 32'h1111_0001;
    tick();
    addr = 5'd19; data_in = 32'h2222_0002;
    tick();
    addr = 5'd25; data_in = 32'hDEAD_BEEF;
    tick();
    wen = 1'b0; addr = 5'd19; #1;
    for (int i = 0; i < 16; i++) img[i] = '0;
    img[1] = 32'd7; img[2] = 32'h1111_0001; img[3] = 32'h2222_0002; img[9] = 32'hDEAD_BEEF;
    chk_exports("burst", img);
    chk("burst_rd19", data_out, 32'h2222_0002);
    addr = 5'd25; #1;
    chk("burst_rd25", data_out, 32'hDEAD_BEEF);
    addr = 5'd15; #1;
    chk("rom15_final", data_out, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
